// File: rtl/sin_datapath_if.sv
// sin_datapath_if: strobe/data bundle between sin_controller and sin_datapath.
// The controller side (master) drives the operand and the per-cycle
// load/init/select/increment strobes; the datapath side (slave) returns the
// terminal-count flag and the accumulated result.
interface sin_datapath_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] x_in;
  logic                    load_xpowertwo;
  logic                    init_xpowertwo;
  logic                    load_mult_reg;
  logic                    init_mult_reg;
  logic                    load_result;
  logic                    init_result;
  logic                    inc_counter;
  logic                    init_counter;
  logic                    sel_mult_in;
  logic                    co;
  logic signed [WIDTH-1:0] result_o;

  modport master (
    output x_in,
    output load_xpowertwo,
    output init_xpowertwo,
    output load_mult_reg,
    output init_mult_reg,
    output load_result,
    output init_result,
    output inc_counter,
    output init_counter,
    output sel_mult_in,
    input  co,
    input  result_o
  );

  modport slave (
    input  x_in,
    input  load_xpowertwo,
    input  init_xpowertwo,
    input  load_mult_reg,
    input  init_mult_reg,
    input  load_result,
    input  init_result,
    input  inc_counter,
    input  init_counter,
    input  sel_mult_in,
    output co,
    output result_o
  );
endinterface

// File: rtl/sin_datapath.sv
// sin_datapath: fixed-point Taylor-series sine datapath.
// Holds x^2, the running term and the running sum, plus a small term counter
// whose terminal count (co) tells the controller to leave the ADD loop.
// Each term is produced as t_{k+1} = (t_k * x2) * coef[k] in two multiplies.
// Optional feature macro: SIN_DP_SAT_EN -- when defined the result adder
// saturates on signed overflow, otherwise it wraps modulo 2^WIDTH.
module sin_datapath #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 14,
  parameter int N_TERMS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sin_datapath_if.slave dp
);

  localparam logic [2:0] CNT_LAST = 3'(N_TERMS - 1);
  localparam logic signed [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // c_k = -1/((2k+2)(2k+3)) scaled by 2^FRAC, rounded to nearest, evaluated
  // at elaboration so the ROM tracks any FRAC setting.
  function automatic logic signed [WIDTH-1:0] coef_value(input int k);
    int den;
    den = (2 * k + 2) * (2 * k + 3);
    return WIDTH'(-(((1 << FRAC) + den / 2) / den));
  endfunction

  localparam logic signed [WIDTH-1:0] COEF_ROM [8] = '{
    coef_value(0), coef_value(1), coef_value(2), coef_value(3),
    coef_value(4), coef_value(5), coef_value(6), coef_value(7)
  };

  logic signed [WIDTH-1:0]   x2_q;
  logic signed [WIDTH-1:0]   term_q;
  logic signed [WIDTH-1:0]   result_q;
  logic        [2:0]         cnt_q;

  logic signed [2*WIDTH-1:0] sq_ext;
  logic signed [2*WIDTH-1:0] sq_prod;
  logic signed [WIDTH-1:0]   sq_val;
  logic signed [WIDTH-1:0]   mult_b;
  logic signed [2*WIDTH-1:0] mult_a_ext;
  logic signed [2*WIDTH-1:0] mult_b_ext;
  logic signed [2*WIDTH-1:0] mult_prod;
  logic signed [WIDTH-1:0]   mult_val;
  logic signed [WIDTH-1:0]   sum_val;
  logic                      prod_unused;

  // Squarer: full-width signed x*x, then keep bits [FRAC +: WIDTH], which is
  // the floor shift by FRAC truncated to WIDTH.
  always_comb begin
    sq_ext  = {{WIDTH{dp.x_in[WIDTH-1]}}, dp.x_in};
    sq_prod = sq_ext * sq_ext;
    sq_val  = sq_prod[FRAC +: WIDTH];
  end

  // Multiplier: term times either x2 or the coefficient for the current term
  // index, using the register values from before the edge.
  always_comb begin
    mult_b     = dp.sel_mult_in ? COEF_ROM[cnt_q] : x2_q;
    mult_a_ext = {{WIDTH{term_q[WIDTH-1]}}, term_q};
    mult_b_ext = {{WIDTH{mult_b[WIDTH-1]}}, mult_b};
    mult_prod  = mult_a_ext * mult_b_ext;
    mult_val   = mult_prod[FRAC +: WIDTH];
  end

  // Product bits outside the kept window are intentionally discarded.
  assign prod_unused = ^{sq_prod[2*WIDTH-1:FRAC+WIDTH], sq_prod[FRAC-1:0],
                         mult_prod[2*WIDTH-1:FRAC+WIDTH], mult_prod[FRAC-1:0]};

`ifdef SIN_DP_SAT_EN
  logic signed [WIDTH:0] sum_wide;

  // Saturating adder: one extra bit exposes signed overflow, which is then
  // clamped toward the sign of the true sum.
  always_comb begin
    sum_wide = {result_q[WIDTH-1], result_q} + {term_q[WIDTH-1], term_q};
    sum_val  = sum_wide[WIDTH-1:0];
    if (sum_wide[WIDTH] != sum_wide[WIDTH-1]) begin
      sum_val = sum_wide[WIDTH] ? RES_MIN : RES_MAX;
    end
  end
`else
  logic [1:0] sat_unused;

  // Wrapping adder: plain modulo-2^WIDTH sum.
  always_comb begin
    sum_val    = result_q + term_q;
    sat_unused = {RES_MAX[0], RES_MIN[0]};
  end
`endif

  // x^2 register: cleared by init, captures the squarer on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x2_q <= '0;
    end else if (dp.init_xpowertwo) begin
      x2_q <= '0;
    end else if (dp.load_xpowertwo) begin
      x2_q <= sq_val;
    end
  end

  // Term register: preset to x (first Taylor term) or updated by the multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      term_q <= '0;
    end else if (dp.init_mult_reg) begin
      term_q <= dp.x_in;
    end else if (dp.load_mult_reg) begin
      term_q <= mult_val;
    end
  end

  // Result accumulator: cleared by init, adds the current term on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (dp.init_result) begin
      result_q <= '0;
    end else if (dp.load_result) begin
      result_q <= sum_val;
    end
  end

  // Term counter: saturates at the last term index so co stays asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (dp.init_counter) begin
      cnt_q <= '0;
    end else if (dp.inc_counter && (cnt_q != CNT_LAST)) begin
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign dp.co       = (cnt_q == CNT_LAST);
  assign dp.result_o = result_q;

endmodule

// File: tb/tb_sin_datapath.sv
// tb_sin_datapath: directed scoreboard bench for sin_datapath.
// Stimulus steps push their hand-computed expected result_o/co into a queue;
// a monitor on the falling edge pops and compares once each step has landed.
module tb_sin_datapath;

  localparam int WIDTH = 16;

  localparam logic [8:0] LX2  = 9'h001;
  localparam logic [8:0] IX2  = 9'h002;
  localparam logic [8:0] LM   = 9'h004;
  localparam logic [8:0] IM   = 9'h008;
  localparam logic [8:0] LR   = 9'h010;
  localparam logic [8:0] IR   = 9'h020;
  localparam logic [8:0] INC  = 9'h040;
  localparam logic [8:0] IC   = 9'h080;
  localparam logic [8:0] SEL  = 9'h100;
  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] ALL  = 9'h1ff;

`ifdef SIN_DP_SAT_EN
  localparam logic signed [WIDTH-1:0] OVF_EXP = 16'sd32767;
`else
  localparam logic signed [WIDTH-1:0] OVF_EXP = -16'sd1536;
`endif

  typedef struct {
    string                   name;
    logic signed [WIDTH-1:0] res;
    logic                    co;
    int                      due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle_count = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb [$];

  sin_datapath_if #(.WIDTH(WIDTH)) bus ();

  sin_datapath #(
    .WIDTH  (WIDTH),
    .FRAC   (14),
    .N_TERMS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dp   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Monitor: compare every expectation whose edge has already happened.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cycle_count) begin
      e = sb.pop_front();
      checks++;
      if (bus.result_o !== e.res || bus.co !== e.co) begin
        failures++;
        $display("[TB] FAIL %s: got result_o=%0d co=%0b, expected result_o=%0d co=%0b",
                 e.name, bus.result_o, bus.co, e.res, e.co);
      end
    end
  end

  task automatic applyStimulus(input logic rst_v, input logic [8:0] s,
                               input logic signed [WIDTH-1:0] x);
    @(posedge clk);
    #1;
    rst_n              = rst_v;
    bus.x_in           = x;
    bus.load_xpowertwo = s[0];
    bus.init_xpowertwo = s[1];
    bus.load_mult_reg  = s[2];
    bus.init_mult_reg  = s[3];
    bus.load_result    = s[4];
    bus.init_result    = s[5];
    bus.inc_counter    = s[6];
    bus.init_counter   = s[7];
    bus.sel_mult_in    = s[8];
  endtask

  task automatic checkOutput(input string name, input logic signed [WIDTH-1:0] res,
                             input logic co_v);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.co   = co_v;
    e.due  = cycle_count + 1;
    sb.push_back(e);
  endtask

  task automatic step(input logic rst_v, input logic [8:0] s,
                      input logic signed [WIDTH-1:0] x, input string name,
                      input logic signed [WIDTH-1:0] res, input logic co_v);
    applyStimulus(rst_v, s, x);
    checkOutput(name, res, co_v);
  endtask

  // Controller-style evaluation of sin(x) for x = 0.5 up to the point co rises.
  task automatic runEval(input string tag);
    step(1'b1, IR | IC | IX2 | IM, 16'sd8192, {tag, "_init"},  16'sd0,    1'b0);
    step(1'b1, LX2,                16'sd8192, {tag, "_x2"},    16'sd0,    1'b0);
    step(1'b1, LR,                 16'sd8192, {tag, "_add1"},  16'sd8192, 1'b0);
    step(1'b1, LM,                 16'sd8192, {tag, "_m1a"},   16'sd8192, 1'b0);
    step(1'b1, LM | SEL | INC,     16'sd8192, {tag, "_m1b"},   16'sd8192, 1'b0);
    step(1'b1, LR,                 16'sd8192, {tag, "_add2"},  16'sd7850, 1'b0);
    step(1'b1, LM,                 16'sd8192, {tag, "_m2a"},   16'sd7850, 1'b0);
    step(1'b1, LM | SEL | INC,     16'sd8192, {tag, "_m2b"},   16'sd7850, 1'b0);
    step(1'b1, LR,                 16'sd8192, {tag, "_add3"},  16'sd7854, 1'b0);
    step(1'b1, LM,                 16'sd8192, {tag, "_m3a"},   16'sd7854, 1'b0);
    step(1'b1, LM | SEL | INC,     16'sd8192, {tag, "_m3b"},   16'sd7854, 1'b1);
  endtask

  initial begin
    bus.x_in = 16'sd0;
    {bus.sel_mult_in, bus.init_counter, bus.inc_counter, bus.init_result,
     bus.load_result, bus.init_mult_reg, bus.load_mult_reg,
     bus.init_xpowertwo, bus.load_xpowertwo} = NONE;

    // Reset dominates every strobe
    step(1'b0, ALL,  16'sd8192, "reset_a", 16'sd0, 1'b0);
    step(1'b0, ALL,  16'sd8192, "reset_b", 16'sd0, 1'b0);
    step(1'b1, NONE, 16'sd8192, "release", 16'sd0, 1'b0);

    // Full evaluation, then one extra term (4*x2 -> 1, 1*coef[2] -> -1)
    runEval("eval");
    step(1'b1, LR, 16'sd8192, "eval_add4", 16'sd7853, 1'b1);

    // Counter saturation and re-init
    step(1'b1, IC,   16'sd0, "cnt_init", 16'sd7853, 1'b0);
    step(1'b1, INC,  16'sd0, "cnt_inc1", 16'sd7853, 1'b0);
    step(1'b1, INC,  16'sd0, "cnt_inc2", 16'sd7853, 1'b0);
    step(1'b1, INC,  16'sd0, "cnt_inc3", 16'sd7853, 1'b1);
    step(1'b1, INC,  16'sd0, "cnt_inc4", 16'sd7853, 1'b1);
    step(1'b1, IC,   16'sd0, "cnt_clr",  16'sd7853, 1'b0);

    // Init beats load on the same register
    step(1'b1, IR | IM, 16'sd500, "prio_setup", 16'sd0,   1'b0);
    step(1'b1, LR,      16'sd500, "prio_load",  16'sd500, 1'b0);
    step(1'b1, IR | LR, 16'sd500, "prio_init",  16'sd0,   1'b0);

    // Overflow: 32000 + 32000
    step(1'b1, IR | IM, 16'sd32000, "ovf_setup", 16'sd0,     1'b0);
    step(1'b1, LR,      16'sd32000, "ovf_add1",  16'sd32000, 1'b0);
    step(1'b1, LR,      16'sd32000, "ovf_add2",  OVF_EXP,    1'b0);
    step(1'b1, NONE,    16'sd32000, "ovf_hold",  OVF_EXP,    1'b0);

    // Reset in the middle of an evaluation, after the second term
    step(1'b1, IR | IC | IX2 | IM, 16'sd8192, "mid_init", 16'sd0,    1'b0);
    step(1'b1, LX2,                16'sd8192, "mid_x2",   16'sd0,    1'b0);
    step(1'b1, LR,                 16'sd8192, "mid_add1", 16'sd8192, 1'b0);
    step(1'b1, LM,                 16'sd8192, "mid_m1a",  16'sd8192, 1'b0);
    step(1'b1, LM | SEL | INC,     16'sd8192, "mid_m1b",  16'sd8192, 1'b0);
    step(1'b1, LR,                 16'sd8192, "mid_add2", 16'sd7850, 1'b0);
    step(1'b1, LM | SEL | INC,     16'sd8192, "mid_inc",  16'sd7850, 1'b0);
    step(1'b0, NONE,               16'sd8192, "mid_rst",  16'sd0,    1'b0);
    step(1'b1, INC,                16'sd8192, "post_inc1", 16'sd0,   1'b0);
    step(1'b1, INC,                16'sd8192, "post_inc2", 16'sd0,   1'b0);
    step(1'b1, LR,                 16'sd8192, "post_add0", 16'sd0,   1'b0);
    runEval("rerun");

    applyStimulus(1'b1, NONE, 16'sd0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sin_datapath.md
# sin_datapath

Arithmetic datapath for the Taylor-series sine unit, directly downstream of `sin_controller`. It consumes the controller's per-cycle load/init/select/increment strobes, and returns the `co` terminal-count flag that ends the ADD loop. It evaluates sin(x) ≈ Σ t_k, where t_0 = x and t_{k+1} = t_k · x² · c_k, with c_k = −1/((2k+2)(2k+3)). All values are signed fixed-point.

## Interface
- `WIDTH`, 16: data width (signed two's complement).
- `FRAC`, 14: fractional bits (Q2.14 at default).
- `N_TERMS`, 4: Taylor terms summed; legal range 2..5.
- `clk` in 1: clock, all state updates on rising edge.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `x_in` in WIDTH: operand x. Must be held stable by the upstream block from `init_mult_reg` until `done`.
- `load_xpowertwo` in 1: capture x² into x2 register.
- `init_xpowertwo` in 1: clear x2 register.
- `load_mult_reg` in 1: capture multiplier output into term register.
- `init_mult_reg` in 1: preset term register to `x_in`.
- `load_result` in 1: result ← result + term.
- `init_result` in 1: clear result.
- `inc_counter` in 1: advance term counter.
- `init_counter` in 1: clear term counter.
- `sel_mult_in` in 1: multiplier operand B select (0: x2 register, 1: coefficient ROM).
- `co` out 1: terminal count, counter == N_TERMS−1.
- `result_o` out WIDTH: result register.

## Operation
- Registers:
  - x2 (WIDTH)
  - term (WIDTH)
  - result (WIDTH)
  - cnt (3 bits)
- Squarer: x2 ← (x_in · x_in) >>> FRAC, truncated to WIDTH, on `load_xpowertwo`.
- Multiplier: A = term, B = `sel_mult_in` ? coef[cnt] : x2.
  - Full 2·WIDTH signed product, arithmetic shift right by FRAC (floor), low WIDTH bits kept.
  - Written to term on `load_mult_reg`.
- Coefficient ROM, Q2.14 at default, round-to-nearest: coef[0]=−2731 (−1/6), coef[1]=−819 (−1/20), coef[2]=−390 (−1/42), coef[3]=−228 (−1/72). ROM values are derived as round(c_k·2^FRAC) for non-default FRAC.
- Adder: result + term, WIDTH bits; overflow handling per Configuration.
- Counter:
  - `init_counter` sets 0.
  - `inc_counter` adds 1.
  - Holds at N_TERMS−1; it never wraps.
- `co` is combinational from cnt.
- Priority per register: reset > init > load/inc. Simultaneous init+load on the same register performs the init.
- Distinct registers update independently in the same cycle.
- No strobe asserted: all registers hold.

## Timing
- Reset (`rst_n`=0 at an edge): x2=0, term=0, result=0, cnt=0, so `result_o`=0 and `co`=0. Asynchronous `rst_n` edges have no effect until the next clock.
- Reset mid-computation discards all state. The next operation requires a fresh init sequence.
- Every strobe takes effect at the next rising edge. Latency is 1 cycle, and the new value is visible on outputs immediately after that edge.
- `co` follows cnt with zero added latency. It is sampled by the controller in the same cycle.
- A multiply uses the term/x2/cnt values present before the edge, so `load_mult_reg` and `inc_counter` may be asserted together.
- Per-term sequence driven by the controller:
  - `load_result`
  - `load_mult_reg` with sel=0
  - `load_mult_reg` with sel=1 and `inc_counter` in the same cycle

## Configuration
- `SIN_DP_SAT_EN` defined: the result adder saturates to +2^(WIDTH−1)−1 / −2^(WIDTH−1) on signed overflow.
- `SIN_DP_SAT_EN` undefined: the result adder wraps modulo 2^WIDTH.
- No other behaviour differs.

## Test plan
- Reset: drive strobes high with `rst_n`=0 for 2 cycles → `result_o`=0, `co`=0. Release → still 0 until strobes act.
- Full evaluation, x_in=8192 (0.5), defaults, controller sequence → x2=4096.
  - term sequence: 8192, 2048, −342, −86, 4.
  - `result_o`: 8192, then 7850, then 7854 after three terms.
  - Reference value 7855 (error ≤ 2 LSB).
- Counter: `init_counter`, then 3× `inc_counter` (N_TERMS=4) → `co` rises right after the third edge. A fourth inc keeps cnt=3 and `co`=1. `init_counter` → `co`=0 the next cycle.
- Priority: `init_result` and `load_result` in the same cycle with result=500 → result=0.
- Overflow: x_in=32000, `init_mult_reg`, then `load_result` twice → with `SIN_DP_SAT_EN` `result_o`=32767; without it `result_o`=−1536.
- Mid-op reset: assert `rst_n`=0 after the second term → all outputs 0 the next cycle. Re-run with x_in=8192 → final result 7854.
